// File: rtl/accum_ctrl_pkg.sv
// Shared types for the switch/LED accumulator controller: FSM states and
// the operation encoding carried on the event port.
package accum_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      POST = 2'd2,
      HOLD = 2'd3
   } state_t;

   localparam logic OP_CLEAR = 1'b0;
   localparam logic OP_ADD   = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low push key; o_press pulses for one
// cycle on each accepted released-to-pressed transition.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_key_n,
   output logic o_stable,
   output logic o_press
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable;
   logic          r_prev;
   logic [CW-1:0] r_cnt;

   // Synchronizer idles at the released level so leaving reset never looks like a press.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_stable <= 1'b1;
         r_prev   <= 1'b1;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
         r_prev  <= r_stable;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_stable = r_stable;
   assign o_press  = r_prev & ~r_stable;

endmodule

// File: rtl/switch_accum_ctrl.sv
// Fabric-side switch accumulator: debounced add/clear keys update an 8-bit
// accumulator shown on the LEDs and report each operation as a one-entry event.
module switch_accum_ctrl
   import accum_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int WIDTH           = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             key_clear_n,
   input  logic             key_add_n,
   input  logic [WIDTH-1:0] switch,
   output logic [WIDTH-1:0] led,
   output logic             overflow,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic             evt_op,
   output logic [WIDTH-1:0] evt_data,
   output logic             evt_drop
);

   state_t           r_state;
   state_t           w_next;
   logic             w_stable_clr;
   logic             w_stable_add;
   logic             w_press_clr;
   logic             w_press_add;
   logic [WIDTH-1:0] r_sw_s1;
   logic [WIDTH-1:0] r_sw_s2;
   logic [WIDTH-1:0] r_sw_lat;
   logic             r_op_lat;
   logic [WIDTH-1:0] r_acc;
   logic             r_ovf;
   logic             r_evt_valid;
   logic             r_evt_op;
   logic [WIDTH-1:0] r_evt_data;
   logic             r_evt_drop;
   logic [WIDTH:0]   w_sum;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_key_n  (key_clear_n),
      .o_stable (w_stable_clr),
      .o_press  (w_press_clr)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_add (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_key_n  (key_add_n),
      .o_stable (w_stable_add),
      .o_press  (w_press_add)
   );

   assign w_sum = {1'b0, r_acc} + {1'b0, r_sw_lat};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // HOLD waits for both keys released so a held key yields a single operation.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_press_clr || w_press_add) w_next = EXEC;
         EXEC:    w_next = POST;
         POST:    w_next = HOLD;
         HOLD:    if (w_stable_clr && w_stable_add) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sw_s1     <= '0;
         r_sw_s2     <= '0;
         r_sw_lat    <= '0;
         r_op_lat    <= OP_CLEAR;
         r_acc       <= '0;
         r_ovf       <= 1'b0;
         r_evt_valid <= 1'b0;
         r_evt_op    <= OP_CLEAR;
         r_evt_data  <= '0;
         r_evt_drop  <= 1'b0;
      end else begin
         r_sw_s1 <= switch;
         r_sw_s2 <= r_sw_s1;
         if (r_state == IDLE && (w_press_clr || w_press_add)) begin
            r_op_lat <= w_press_clr ? OP_CLEAR : OP_ADD;
            r_sw_lat <= r_sw_s2;
         end
         if (r_state == EXEC) begin
            if (r_op_lat == OP_ADD) begin
               r_acc <= w_sum[WIDTH-1:0];
               if (w_sum[WIDTH]) r_ovf <= 1'b1;
            end else begin
               r_acc <= '0;
               r_ovf <= 1'b0;
            end
         end
         // A load in POST wins over a same-cycle consume; only an unconsumed event counts as dropped.
         if (r_state == POST) begin
            r_evt_valid <= 1'b1;
            r_evt_op    <= r_op_lat;
            r_evt_data  <= r_acc;
            if (r_evt_valid && !evt_ready) r_evt_drop <= 1'b1;
         end else if (r_evt_valid && evt_ready) begin
            r_evt_valid <= 1'b0;
         end
      end
   end

   assign led       = r_acc;
   assign overflow  = r_ovf;
   assign evt_valid = r_evt_valid;
   assign evt_op    = r_evt_op;
   assign evt_data  = r_evt_data;
   assign evt_drop  = r_evt_drop;

endmodule

// File: tb/tb_switch_accum_ctrl.sv
// Directed bench for switch_accum_ctrl with a short debounce window.
module tb_switch_accum_ctrl;

   localparam int N = 4;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         key_clear_n = 1'b1;
   logic         key_add_n = 1'b1;
   logic [W-1:0] switch = '0;
   logic [W-1:0] led;
   logic         overflow;
   logic         evt_valid;
   logic         evt_ready = 1'b0;
   logic         evt_op;
   logic [W-1:0] evt_data;
   logic         evt_drop;

   int n_tests = 0;
   int n_fail  = 0;

   switch_accum_ctrl #(.DEBOUNCE_CYCLES(N), .WIDTH(W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .key_clear_n (key_clear_n),
      .key_add_n   (key_add_n),
      .switch      (switch),
      .led         (led),
      .overflow    (overflow),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_op      (evt_op),
      .evt_data    (evt_data),
      .evt_drop    (evt_drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_op(input logic clr, input logic add, input logic [W-1:0] sw);
      switch = sw;
      edges(3);
      key_clear_n = ~clr;
      key_add_n   = ~add;
      edges(12);
      key_clear_n = 1'b1;
      key_add_n   = 1'b1;
      edges(10);
   endtask

   task automatic consume();
      evt_ready = 1'b1;
      edges(1);
      evt_ready = 1'b0;
   endtask

   initial begin
      // Reset state
      switch = 8'h05;
      #23;
      check("rst_led", led, 0);
      check("rst_valid", evt_valid, 0);
      check("rst_drop", evt_drop, 0);
      reset_n = 1'b1;
      edges(3);

      // Held add key: timing and a single operation
      key_add_n = 1'b0;
      edges(7);
      check("add_led_e7", led, 8'h00);
      edges(1);
      check("add_led_e8", led, 8'h05);
      check("add_valid_e8", evt_valid, 0);
      edges(1);
      check("add_valid_e9", evt_valid, 1);
      check("add_op", evt_op, 1);
      check("add_data", evt_data, 8'h05);
      edges(11);
      check("held_led", led, 8'h05);
      check("held_drop", evt_drop, 0);
      key_add_n = 1'b1;
      edges(10);
      check("held_valid", evt_valid, 1);
      consume();
      check("consume_valid", evt_valid, 0);

      // Short glitches never register
      for (int i = 0; i < 5; i++) begin
         key_add_n = 1'b0;
         edges(3);
         key_add_n = 1'b1;
         edges(3);
      end
      edges(10);
      check("glitch_led", led, 8'h05);
      check("glitch_valid", evt_valid, 0);

      // Overflow then clear
      press_op(1'b0, 1'b1, 8'hEB);
      check("f0_led", led, 8'hF0);
      check("f0_ovf", overflow, 0);
      consume();
      press_op(1'b0, 1'b1, 8'h20);
      check("ovf_led", led, 8'h10);
      check("ovf_flag", overflow, 1);
      check("ovf_data", evt_data, 8'h10);
      consume();
      press_op(1'b1, 1'b0, 8'hAA);
      check("clr_led", led, 8'h00);
      check("clr_ovf", overflow, 0);
      check("clr_valid", evt_valid, 1);
      check("clr_op", evt_op, 0);
      check("clr_data", evt_data, 8'h00);
      consume();

      // Simultaneous keys: clear wins
      press_op(1'b0, 1'b1, 8'h10);
      check("pre_both_led", led, 8'h10);
      consume();
      press_op(1'b1, 1'b1, 8'h22);
      check("both_led", led, 8'h00);
      check("both_op", evt_op, 0);
      check("both_data", evt_data, 8'h00);
      consume();
      check("both_single", evt_valid, 0);

      // Overwritten event sets sticky drop
      press_op(1'b0, 1'b1, 8'h01);
      check("drop1_data", evt_data, 8'h01);
      check("drop1_flag", evt_drop, 0);
      press_op(1'b0, 1'b1, 8'h02);
      check("drop2_data", evt_data, 8'h03);
      check("drop2_flag", evt_drop, 1);
      check("drop2_valid", evt_valid, 1);
      consume();
      check("drop_after_valid", evt_valid, 0);
      check("drop_sticky", evt_drop, 1);

      // Reset while in EXEC
      press_op(1'b0, 1'b1, 8'h30);
      check("acc33_led", led, 8'h33);
      switch = 8'h11;
      edges(3);
      key_add_n = 1'b0;
      edges(7);
      check("exec_led_pre", led, 8'h33);
      reset_n = 1'b0;
      #1;
      check("mid_led", led, 0);
      check("mid_ovf", overflow, 0);
      check("mid_valid", evt_valid, 0);
      check("mid_op", evt_op, 0);
      check("mid_data", evt_data, 0);
      check("mid_drop", evt_drop, 0);
      key_add_n = 1'b1;
      edges(2);
      reset_n = 1'b1;
      edges(12);
      check("post_rst_led", led, 0);
      check("post_rst_valid", evt_valid, 0);
      press_op(1'b0, 1'b1, 8'h07);
      check("post_rst_add_led", led, 8'h07);
      check("post_rst_add_valid", evt_valid, 1);
      check("post_rst_add_op", evt_op, 1);
      check("post_rst_add_data", evt_data, 8'h07);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
